// File: rtl/jarvis_pkg.sv
// Shared JARVIS RV32 core types: datapath width, fetch FSM encodings, fetch buffer entry.
// Pure declarations; no latency or flow control of its own.
package jarvis_pkg;

  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;

  typedef enum logic {
    FETCH_RUN   = 1'b0,
    FETCH_FLUSH = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
    return a & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Shift-register FIFO with the head in slot 0; 1 cycle push-to-head, head is a flop.
// No internal backpressure: the caller guarantees push only with a free slot or a same-cycle pop.
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop,
  input  logic                     clear,
  output logic [WIDTH-1:0]         head_dat,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem     [DEPTH];
  logic [WIDTH-1:0] mem_nxt [DEPTH];
  logic [AW-1:0]    wr_idx;

  // A pop shifts every entry down one slot; the push lands behind the surviving entries.
  always_comb begin
    mem_nxt = mem;
    wr_idx  = AW'(count - CW'(pop));
    if (pop) begin
      for (int i = 0; i < DEPTH - 1; i++) mem_nxt[i] = mem[i+1];
    end
    if (push) mem_nxt[wr_idx] = push_dat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      count <= '0;
    end else begin
      mem   <= mem_nxt;
      count <= clear ? '0 : count + CW'(push) - CW'(pop);
    end
  end

  assign head_dat = mem[0];
  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));

endmodule

// File: rtl/instr_fetch.sv
// RV32 fetch stage: owns the PC, issues in-order imem reads, buffers {pc, instr} for decode.
// Response to instr_valid is 1 cycle; requests are credit-limited so every response has a buffer slot.
module instr_fetch
  import jarvis_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_resp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            instr_valid,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  input  logic            instr_ready
);
  localparam int              CW        = $clog2(FIFO_DEPTH) + 1;
  localparam logic [XLEN-1:0] STEP      = XLEN'(INSTR_BYTES);
  localparam logic [CW:0]     DEPTH_LIM = (CW+1)'(FIFO_DEPTH);

  fetch_state_e    state, state_nxt;
  logic [XLEN-1:0] fetch_pc, resp_pc, redirect_al;
  logic [CW-1:0]   outstanding, discard_cnt, fifo_count, out_nxt, cnt_nxt;
  logic [CW:0]     credit_used;
  logic            req_hs, push, pop, fifo_empty, fifo_full;
  fetch_entry_t    push_dat, head_dat;

  assign redirect_al = word_align(redirect_pc);
  assign req_hs      = imem_req_valid && imem_req_ready;
  assign pop         = instr_valid && instr_ready;
  assign push        = imem_resp_valid && (state == FETCH_RUN) && !redirect_valid
                       && (!fifo_full || pop);
  assign push_dat    = '{pc: resp_pc, instr: imem_resp_data};

  // Next-cycle occupancy drives both the flush decision and the registered request valid.
  always_comb begin
    out_nxt     = outstanding + CW'(req_hs) - CW'(imem_resp_valid);
    cnt_nxt     = redirect_valid ? '0 : fifo_count + CW'(push) - CW'(pop);
    credit_used = {1'b0, out_nxt} + {1'b0, cnt_nxt};
    state_nxt   = state;
    if (redirect_valid)
      state_nxt = (out_nxt != '0) ? FETCH_FLUSH : FETCH_RUN;
    else if (state == FETCH_FLUSH && imem_resp_valid && discard_cnt == CW'(1))
      state_nxt = FETCH_RUN;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= FETCH_RUN;
      fetch_pc       <= RESET_PC;
      resp_pc        <= RESET_PC;
      outstanding    <= '0;
      discard_cnt    <= '0;
      imem_req_valid <= 1'b0;
    end else begin
      state          <= state_nxt;
      outstanding    <= out_nxt;
      imem_req_valid <= (state_nxt == FETCH_RUN) && (credit_used < DEPTH_LIM);
      if (redirect_valid) begin
        // Everything still in flight after this edge is stale, including a same-cycle request.
        fetch_pc    <= redirect_al;
        resp_pc     <= redirect_al;
        discard_cnt <= out_nxt;
      end else begin
        if (req_hs) fetch_pc <= fetch_pc + STEP;
        if (push)   resp_pc  <= resp_pc + STEP;
        if (state == FETCH_FLUSH && imem_resp_valid) discard_cnt <= discard_cnt - CW'(1);
      end
    end
  end

  fetch_fifo #(
    .WIDTH($bits(fetch_entry_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_dat (push_dat),
    .pop      (pop),
    .clear    (redirect_valid),
    .head_dat (head_dat),
    .count    (fifo_count),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

  assign imem_req_addr = fetch_pc;
  assign instr_valid   = !fifo_empty;
  assign instr         = head_dat.instr;
  assign instr_pc      = head_dat.pc;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: behavioural in-order imem with settable latency,
// redirect vector table plus hand-written reset, backpressure, stall and same-cycle sequences.
module tb_instr_fetch;

  logic        clk;
  logic        rst_n;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;

  instr_fetch #(.RESET_PC(32'h0000_0100), .FIFO_DEPTH(2)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_req_valid  (imem_req_valid),
    .imem_req_addr   (imem_req_addr),
    .imem_req_ready  (imem_req_ready),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .instr_valid     (instr_valid),
    .instr           (instr),
    .instr_pc        (instr_pc),
    .instr_ready     (instr_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int lat    = 1;
  int mcyc   = 0;
  int edge_n = 0;

  typedef struct {
    int          due;
    logic [31:0] addr;
  } pend_t;
  pend_t       pend[$];
  logic [31:0] req_log[$];
  int          req_edge[$];
  logic [31:0] got_pc[$];
  logic [31:0] got_ins[$];
  int          got_edge[$];

  typedef struct {
    logic [31:0] tgt;
    int          lat;
    logic [31:0] exp_pc;
    logic [31:0] exp_ins;
    logic [31:0] exp_pc2;
  } vec_t;
  vec_t vecs[4];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h0000_0100) ? 32'h3E80_8093 : (a ^ 32'hDEAD_0000);
  endfunction

  function automatic logic [31:0] gpc(input int i);
    return (i < got_pc.size()) ? got_pc[i] : 32'hxxxx_xxxx;
  endfunction
  function automatic logic [31:0] gins(input int i);
    return (i < got_ins.size()) ? got_ins[i] : 32'hxxxx_xxxx;
  endfunction
  function automatic logic [31:0] greq(input int i);
    return (i < req_log.size()) ? req_log[i] : 32'hxxxx_xxxx;
  endfunction
  function automatic int gedge(input int i);
    return (i < got_edge.size()) ? got_edge[i] : -1000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Memory: in-order responses, lat cycles after the accepting edge, never backpressured.
  initial begin
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'h0;
    forever begin
      @(posedge clk);
      mcyc++;
      if (!rst_n) pend.delete();
      else if (imem_req_valid && imem_req_ready)
        pend.push_back('{due: mcyc + lat - 1, addr: imem_req_addr});
      #1;
      if (rst_n && pend.size() > 0 && pend[0].due <= mcyc) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = mem_word(pend[0].addr);
        void'(pend.pop_front());
      end else begin
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
      end
    end
  end

  always @(posedge clk) begin
    edge_n++;
    if (rst_n && imem_req_valid && imem_req_ready) begin
      req_log.push_back(imem_req_addr);
      req_edge.push_back(edge_n);
    end
    if (rst_n && instr_valid && instr_ready) begin
      got_pc.push_back(instr_pc);
      got_ins.push_back(instr);
      got_edge.push_back(edge_n);
    end
  end

  task automatic clear_logs();
    req_log.delete();
    req_edge.delete();
    got_pc.delete();
    got_ins.delete();
    got_edge.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    clear_logs();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_got(input int n, input string name);
    int k = 0;
    while (got_pc.size() < n && k < 200) begin
      @(posedge clk);
      #2;
      k++;
    end
    if (got_pc.size() < n) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: got %0d instructions, required %0d", name, got_pc.size(), n);
    end
  endtask

  task automatic wait_req(input int n, input string name);
    int k = 0;
    while (req_log.size() < n && k < 200) begin
      @(posedge clk);
      #2;
      k++;
    end
    if (req_log.size() < n) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: got %0d requests, required %0d", name, req_log.size(), n);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int mark, mark_r, k;
    vecs[0] = '{tgt: 32'h0000_0400, lat: 1, exp_pc: 32'h0000_0400, exp_ins: 32'hDEAD_0400, exp_pc2: 32'h0000_0404};
    vecs[1] = '{tgt: 32'h0000_020B, lat: 2, exp_pc: 32'h0000_0208, exp_ins: 32'hDEAD_0208, exp_pc2: 32'h0000_020C};
    vecs[2] = '{tgt: 32'h0000_1002, lat: 3, exp_pc: 32'h0000_1000, exp_ins: 32'hDEAD_1000, exp_pc2: 32'h0000_1004};
    vecs[3] = '{tgt: 32'hFFFF_FFFF, lat: 1, exp_pc: 32'hFFFF_FFFC, exp_ins: 32'h2152_FFFC, exp_pc2: 32'h0000_0000};

    rst_n          = 1'b1;
    imem_req_ready = 1'b1;
    instr_ready    = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    #1 rst_n = 1'b0;
    #1;
    chk("reset_req_valid", 32'(imem_req_valid), 32'h0);
    chk("reset_req_addr", imem_req_addr, 32'h0000_0100);
    chk("reset_instr_valid", 32'(instr_valid), 32'h0);
    chk("reset_instr", instr, 32'h0);
    chk("reset_instr_pc", instr_pc, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Stream with 1-cycle memory and an always-ready consumer.
    wait_got(4, "stream");
    chk("stream_req0", greq(0), 32'h0000_0100);
    chk("stream_req1", greq(1), 32'h0000_0104);
    chk("stream_req2", greq(2), 32'h0000_0108);
    chk("stream_pc0", gpc(0), 32'h0000_0100);
    chk("stream_ins0", gins(0), 32'h3E80_8093);
    chk("stream_pc1", gpc(1), 32'h0000_0104);
    chk("stream_ins1", gins(1), 32'hDEAD_0104);
    chk("stream_first_latency", 32'(gedge(0) - req_edge[0]), 32'd2);

    // Redirect vectors applied mid-stream.
    for (int i = 0; i < 4; i++) begin
      lat = vecs[i].lat;
      repeat (3) @(posedge clk);
      #2;
      redirect_valid = 1'b1;
      redirect_pc    = vecs[i].tgt;
      @(posedge clk);
      #2;
      redirect_valid = 1'b0;
      mark   = got_pc.size();
      mark_r = req_log.size();
      wait_got(mark + 2, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d_pc", i), gpc(mark), vecs[i].exp_pc);
      chk($sformatf("vec%0d_ins", i), gins(mark), vecs[i].exp_ins);
      chk($sformatf("vec%0d_pc2", i), gpc(mark + 1), vecs[i].exp_pc2);
      chk($sformatf("vec%0d_req", i), greq(mark_r), vecs[i].exp_pc);
    end

    // Decode backpressure fills the buffer and stops requests.
    lat = 1;
    instr_ready = 1'b0;
    do_reset();
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("bp_instr_valid", 32'(instr_valid), 32'h1);
    chk("bp_instr_pc", instr_pc, 32'h0000_0100);
    chk("bp_req_valid", 32'(imem_req_valid), 32'h0);
    chk("bp_outstanding", 32'(pend.size()), 32'd0);
    chk("bp_req_count", 32'(req_log.size()), 32'd2);
    @(posedge clk);
    #2;
    instr_ready = 1'b1;
    wait_got(3, "bp_drain");
    chk("bp_pc0", gpc(0), 32'h0000_0100);
    chk("bp_pc1", gpc(1), 32'h0000_0104);
    chk("bp_pc2", gpc(2), 32'h0000_0108);
    chk("bp_no_gap", 32'(gedge(1) - gedge(0)), 32'd1);

    // Memory stall: request must hold stable.
    do_reset();
    wait_req(1, "stall_first");
    imem_req_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("stall%0d_valid", i), 32'(imem_req_valid), 32'h1);
      chk($sformatf("stall%0d_addr", i), imem_req_addr, 32'h0000_0104);
      @(posedge clk);
    end
    #2;
    imem_req_ready = 1'b1;
    wait_got(3, "stall_drain");
    chk("stall_pc0", gpc(0), 32'h0000_0100);
    chk("stall_pc1", gpc(1), 32'h0000_0104);
    chk("stall_pc2", gpc(2), 32'h0000_0108);

    // Redirect with two requests in flight at 3-cycle latency.
    lat = 3;
    do_reset();
    wait_req(2, "flush_reqs");
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    @(posedge clk);
    #2;
    redirect_valid = 1'b0;
    mark_r = req_log.size();
    @(negedge clk);
    chk("flush_no_req_a", 32'(imem_req_valid), 32'h0);
    @(negedge clk);
    chk("flush_no_req_b", 32'(imem_req_valid), 32'h0);
    @(negedge clk);
    chk("flush_req_valid", 32'(imem_req_valid), 32'h1);
    chk("flush_req_addr", imem_req_addr, 32'h0000_0200);
    wait_got(1, "flush_deliver");
    chk("flush_pc", gpc(0), 32'h0000_0200);
    chk("flush_ins", gins(0), 32'hDEAD_0200);
    chk("flush_req_after", greq(mark_r), 32'h0000_0200);

    // Redirect coinciding with a response and a decode handshake.
    lat = 1;
    do_reset();
    k = 0;
    while (!(imem_resp_valid && instr_valid) && k < 100) begin
      @(posedge clk);
      #2;
      k++;
    end
    chk("simul_found", 32'(imem_resp_valid && instr_valid), 32'h1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0300;
    @(posedge clk);
    #2;
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("simul_instr_valid_drop", 32'(instr_valid), 32'h0);
    chk("simul_req_addr", imem_req_addr, 32'h0000_0300);
    wait_got(2, "simul_deliver");
    chk("simul_kept_pc", gpc(0), 32'h0000_0100);
    chk("simul_next_pc", gpc(1), 32'h0000_0300);
    chk("simul_next_ins", gins(1), 32'hDEAD_0300);

    // Asynchronous reset between clock edges.
    repeat (4) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("areset_req_valid", 32'(imem_req_valid), 32'h0);
    chk("areset_req_addr", imem_req_addr, 32'h0000_0100);
    chk("areset_instr_valid", 32'(instr_valid), 32'h0);
    chk("areset_instr", instr, 32'h0);
    chk("areset_instr_pc", instr_pc, 32'h0);
    repeat (2) @(posedge clk);
    clear_logs();
    @(negedge clk);
    rst_n = 1'b1;
    wait_req(1, "areset_req");
    chk("areset_first_req", greq(0), 32'h0000_0100);
    wait_got(1, "areset_deliver");
    chk("areset_first_pc", gpc(0), 32'h0000_0100);
    chk("areset_first_ins", gins(0), 32'h3E80_8093);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
